// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
// Carries the instruction fields and flags in, and every control strobe and status output back.
interface multi_cycle_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        memRdy;

  logic        pcWr;
  logic        irWr;
  logic        nPC_sel;
  logic        jumpCrt;
  logic        regWr;
  logic [1:0]  regDst;
  logic [1:0]  memToReg;
  logic        aluSrc;
  logic [1:0]  aluOp;
  logic        extOp;
  logic        memWr;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        illegal;

  modport master (
    input  op, funct, zero, memRdy,
    output pcWr, irWr, nPC_sel, jumpCrt, regWr, regDst, memToReg,
           aluSrc, aluOp, extOp, memWr, state, retired, illegal
  );

  modport slave (
    output op, funct, zero, memRdy,
    input  pcWr, irWr, nPC_sel, jumpCrt, regWr, regDst, memToReg,
           aluSrc, aluOp, extOp, memWr, state, retired, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEMACC/WB/TRAP FSM with Moore/Mealy control decode.
// Optional MULTI_CYCLE_CTRL_MEMWAIT_EN: MEMACC stalls until memRdy is high.
module multi_cycle_ctrl (
  input  logic                  clock,
  input  logic                  reset,
  multi_cycle_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMACC = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  logic        mem_go;

  logic is_addu, is_subu, is_rtype, is_ori, is_lw, is_sw;
  logic is_beq, is_lui, is_j, is_jal, is_illegal;

`ifdef MULTI_CYCLE_CTRL_MEMWAIT_EN
  assign mem_go = bus.memRdy;
`else
  // Without the wait option MEMACC always completes in one cycle.
  logic unused_mem_rdy;
  assign unused_mem_rdy = bus.memRdy;
  assign mem_go         = 1'b1;
`endif

  always_comb begin
    is_addu    = (bus.op == OP_RTYPE) && (bus.funct == FN_ADDU);
    is_subu    = (bus.op == OP_RTYPE) && (bus.funct == FN_SUBU);
    is_rtype   = is_addu || is_subu;
    is_ori     = (bus.op == OP_ORI);
    is_lw      = (bus.op == OP_LW);
    is_sw      = (bus.op == OP_SW);
    is_beq     = (bus.op == OP_BEQ);
    is_lui     = (bus.op == OP_LUI);
    is_j       = (bus.op == OP_J);
    is_jal     = (bus.op == OP_JAL);
    is_illegal = !(is_rtype || is_ori || is_lw || is_sw || is_beq ||
                   is_lui || is_j || is_jal);
  end

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    bus.pcWr     = 1'b0;
    bus.irWr     = 1'b0;
    bus.nPC_sel  = 1'b0;
    bus.jumpCrt  = 1'b0;
    bus.regWr    = 1'b0;
    bus.regDst   = 2'b00;
    bus.memToReg = 2'b00;
    bus.aluSrc   = 1'b0;
    bus.aluOp    = 2'b00;
    bus.extOp    = 1'b0;
    bus.memWr    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        bus.irWr = 1'b1;
        bus.pcWr = 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        if (is_j || is_jal) begin
          bus.pcWr    = 1'b1;
          bus.jumpCrt = 1'b1;
          retire      = 1'b1;
          state_d     = ST_FETCH;
          if (is_jal) begin
            bus.regWr    = 1'b1;
            bus.regDst   = 2'b10;
            bus.memToReg = 2'b10;
          end
        end else if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_beq) begin
          bus.aluOp   = 2'b01;
          bus.nPC_sel = 1'b1;
          bus.pcWr    = bus.zero;
          retire      = 1'b1;
          state_d     = ST_FETCH;
        end else if (is_rtype) begin
          bus.aluOp = is_subu ? 2'b01 : 2'b00;
          state_d   = ST_WB;
        end else if (is_ori) begin
          bus.aluSrc = 1'b1;
          bus.aluOp  = 2'b10;
          state_d    = ST_WB;
        end else if (is_lui) begin
          bus.aluSrc = 1'b1;
          bus.aluOp  = 2'b11;
          state_d    = ST_WB;
        end else begin
          // lw / sw: effective address = base + sign-extended offset
          bus.aluSrc = 1'b1;
          bus.extOp  = 1'b1;
          state_d    = ST_MEMACC;
        end
      end

      ST_MEMACC: begin
        bus.memWr = is_sw;
        if (mem_go) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        bus.regWr    = 1'b1;
        bus.regDst   = is_rtype ? 2'b01 : 2'b00;
        bus.memToReg = is_lw ? 2'b01 : 2'b00;
        retire       = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Write strobes must stay quiet for the whole reset window, even though state_q reads FETCH.
    if (!reset) begin
      bus.pcWr  = 1'b0;
      bus.irWr  = 1'b0;
      bus.regWr = 1'b0;
      bus.memWr = 1'b0;
    end
  end

  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl: per-cycle state and control-vector checks per instruction.
module tb_multi_cycle_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_retired;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control view: pcWr irWr nPC_sel jumpCrt regWr regDst memToReg aluSrc aluOp extOp memWr
  logic [13:0] ctl_obs;
  assign ctl_obs = {bus.pcWr, bus.irWr, bus.nPC_sel, bus.jumpCrt, bus.regWr, bus.regDst,
                    bus.memToReg, bus.aluSrc, bus.aluOp, bus.extOp, bus.memWr};

  function automatic logic [13:0] cv(input logic pc, input logic ir, input logic npc,
                                     input logic jc, input logic rw, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic as, input logic [1:0] ao,
                                     input logic eo, input logic mw);
    return {pc, ir, npc, jc, rw, rd, m2r, as, ao, eo, mw};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  es [5];
  logic [13:0] ec [5];

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int n);
    bus.op    = o;
    bus.funct = f;
    bus.zero  = z;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_st%0d", name, i), 32'(bus.state), 32'(es[i]));
      check($sformatf("%s_ctl%0d", name, i), 32'(ctl_obs), 32'(ec[i]));
      step();
    end
    exp_retired = exp_retired + 32'd1;
    check($sformatf("%s_done_st", name), 32'(bus.state), 32'd0);
    check($sformatf("%s_retired", name), bus.retired, exp_retired);
    $display("instr %s cycles=%0d retired=%0d", name, n, bus.retired);
  endtask

  logic [13:0] c_f, c_z;

  initial begin
    checks      = 0;
    errors      = 0;
    exp_retired = 32'd0;
    c_f = cv(1,1,0,0,0,2'd0,2'd0,0,2'd0,0,0);
    c_z = 14'd0;

    rst_n      = 1'b0;
    bus.op     = 6'd0;
    bus.funct  = 6'd0;
    bus.zero   = 1'b0;
`ifdef MULTI_CYCLE_CTRL_MEMWAIT_EN
    bus.memRdy = 1'b1;
`else
    bus.memRdy = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   32'(bus.state), 32'd0);
    check("rst_retired", bus.retired, 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_strobes", 32'({bus.pcWr, bus.irWr, bus.regWr, bus.memWr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    ec = '{c_f, c_z, c_z, cv(0,0,0,0,1,2'd1,2'd0,0,2'd0,0,0), c_z};
    run_instr("addu", 6'h00, 6'h21, 1'b0, 4);

    ec = '{c_f, c_z, cv(0,0,0,0,0,2'd0,2'd0,0,2'd1,0,0), cv(0,0,0,0,1,2'd1,2'd0,0,2'd0,0,0), c_z};
    run_instr("subu", 6'h00, 6'h23, 1'b0, 4);

    ec = '{c_f, c_z, cv(0,0,0,0,0,2'd0,2'd0,1,2'd2,0,0), cv(0,0,0,0,1,2'd0,2'd0,0,2'd0,0,0), c_z};
    run_instr("ori", 6'h0D, 6'h3F, 1'b0, 4);

    ec = '{c_f, c_z, cv(0,0,0,0,0,2'd0,2'd0,1,2'd3,0,0), cv(0,0,0,0,1,2'd0,2'd0,0,2'd0,0,0), c_z};
    run_instr("lui", 6'h0F, 6'h00, 1'b0, 4);

    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    ec = '{c_f, c_z, cv(0,0,0,0,0,2'd0,2'd0,1,2'd0,1,0), c_z, cv(0,0,0,0,1,2'd0,2'd1,0,2'd0,0,0)};
    run_instr("lw", 6'h23, 6'h00, 1'b0, 5);

    // With the wait option off, memRdy is low here and must be ignored.
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    ec = '{c_f, c_z, cv(0,0,0,0,0,2'd0,2'd0,1,2'd0,1,0), cv(0,0,0,0,0,2'd0,2'd0,0,2'd0,0,1), c_z};
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 4);

    es = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    ec = '{c_f, c_z, cv(1,0,1,0,0,2'd0,2'd0,0,2'd1,0,0), c_z, c_z};
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 3);
    ec = '{c_f, c_z, cv(0,0,1,0,0,2'd0,2'd0,0,2'd1,0,0), c_z, c_z};
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 3);

    es = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    ec = '{c_f, cv(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,0), c_z, c_z, c_z};
    run_instr("j", 6'h02, 6'h00, 1'b0, 2);
    ec = '{c_f, cv(1,0,0,1,1,2'd2,2'd2,0,2'd0,0,0), c_z, c_z, c_z};
    run_instr("jal", 6'h03, 6'h00, 1'b0, 2);

`ifdef MULTI_CYCLE_CTRL_MEMWAIT_EN
    bus.op = 6'h2B;
    step(); step(); step();
    check("swwait_enter", 32'(bus.state), 32'd3);
    bus.memRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.memRdy = 1'b1;
      check($sformatf("swwait_memwr%0d", i), 32'(bus.memWr), 32'd1);
      check($sformatf("swwait_st%0d", i), 32'(bus.state), 32'd3);
      step();
    end
    exp_retired = exp_retired + 32'd1;
    check("swwait_done_st", 32'(bus.state), 32'd0);
    check("swwait_retired", bus.retired, exp_retired);
    $display("instr sw_wait retired=%0d", bus.retired);
`endif

    // Reset in MEMACC of an lw aborts it immediately.
    bus.op = 6'h23;
    step(); step(); step();
    check("lwrst_enter", 32'(bus.state), 32'd3);
    rst_n = 1'b0;
    #1;
    check("lwrst_memwr", 32'(bus.memWr), 32'd0);
    check("lwrst_regwr", 32'(bus.regWr), 32'd0);
    check("lwrst_state", 32'(bus.state), 32'd0);
    check("lwrst_retired", bus.retired, 32'd0);
    exp_retired = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("lwrst_first_edge", 32'(bus.state), 32'd1);
    step(); step(); step();
    check("lwrst_fin_st", 32'(bus.state), 32'd4);
    step();
    exp_retired = exp_retired + 32'd1;
    check("lwrst_fin_retired", bus.retired, exp_retired);
    $display("instr lw_after_reset retired=%0d", bus.retired);

    bus.op    = 6'h3F;
    bus.funct = 6'h00;
    step(); step();
    check("trap_state", 32'(bus.state), 32'd5);
    check("trap_illegal", 32'(bus.illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("trap_ctl%0d", i), 32'(ctl_obs), 32'd0);
      check($sformatf("trap_st%0d", i), 32'(bus.state), 32'd5);
      step();
    end
    check("trap_retired", bus.retired, exp_retired);
    rst_n = 1'b0;
    #1;
    check("trap_rst_illegal", 32'(bus.illegal), 32'd0);
    check("trap_rst_state", 32'(bus.state), 32'd0);
    $display("instr op3F trapped and cleared by reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    bus.op    = 6'h00;
    bus.funct = 6'h20;
    step(); step();
    check("badfunct_state", 32'(bus.state), 32'd5);
    check("badfunct_illegal", 32'(bus.illegal), 32'd1);
    check("badfunct_retired", bus.retired, 32'd0);
    $display("instr rtype funct 0x20 trapped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
